fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding/hazard controller for the 16-bit pipeline. Tracks destination tags of
//  instructions in EX, MEM and WB. Produces registered F1/F2 select pairs for both ALU
//  operand forwarding muxes (F1 = EX/MEM->ALU, F2 = MEM/WB->ALU) and a load-use stall.
//  Sits between ID decode and the ID/EX flop, directly upstream of the operand muxes.
// PARAMETERS
//  RA_W     4  register address width
//  CNT_W   16  width of the stall performance counter
//  ZERO_REG 1  1: r0 hard-wired zero, never forwarded or stalled on
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      asynchronous, active-high reset
//  id_rs        in   RA_W   source A of instruction in ID
//  id_rt        in   RA_W   source B of instruction in ID
//  id_uses_rt   in   1      1: instruction in ID reads id_rt
//  id_rd        in   RA_W   destination of instruction in ID
//  id_regwrite  in   1      instruction in ID writes id_rd
//  id_memread   in   1      instruction in ID is a load
//  flush        in   1      branch taken: squash instruction in ID
//  fa_f1,fa_f2  out  1      operand A mux selects, valid while instr is in EX
//  fb_f1,fb_f2  out  1      operand B mux selects, valid while instr is in EX
//  stall        out  1      load-use hazard: hold PC and IF/ID (combinational)
//  stall_cnt    out  CNT_W  cycles with stall=1 since reset
// BEHAVIOUR
//  Tag pipeline (flops): EX{rd,regwrite,memread} <- ID inputs; MEM{rd,regwrite,memread} <- EX;
//   WB{rd,regwrite} <- MEM. All advance every cycle.
//  Bubble: if stall|flush, EX tag loads regwrite=0, memread=0, rd=0. MEM/WB advance normally.
//  hit(t,r) = t.regwrite & (t.rd==r) & !(ZERO_REG & r==0).
//  stall = hit(EX,id_rs)&EX.memread | hit(EX,id_rt)&EX.memread&id_uses_rt. Gated to 0 by flush.
//  Forward selects are computed in ID for the next cycle and registered. Next-cycle
//   EX/MEM = current EX tag; next-cycle MEM/WB = current MEM tag.
//  fa_f1_n = hit(EX,id_rs) & !EX.memread.
//  fa_f2_n = hit(MEM,id_rs) & !fa_f1_n. A younger producer wins.
//  fb_* are the same functions using id_rt, and are additionally ANDed with id_uses_rt.
//  F1 and F2 are never both 1 (one-hot-or-zero). Downstream F1 priority is therefore not relied on.
//  On stall|flush, all four select flops load 0. The bubble in EX selects the ID/EX value.
//  A stalled load-user re-evaluates next cycle. The load is then in MEM, so the user sees
//   F2=1 (MEM/WB forward) in EX.
//  stall_cnt: +1 each cycle stall=1; saturates at all-ones; never wraps.
//  Reset (async, any cycle incl. mid-stall): all tags cleared (regwrite=0, memread=0, rd=0),
//   fa_*/fb_*=0, stall_cnt=0. stall=0 follows immediately from the cleared tags.
//  Latency: selects 1 cycle after ID presentation; stall is same-cycle.
// TESTING
//  1 ALU chain: ADD r3 then SUB r4,r3,r1 in back-to-back IDs -> SUB in EX has fa_f1=1, fa_f2=0.
//  2 Gap of one: ADD r3, NOP, AND r5,r3,r3 -> AND in EX has fa_f2=fb_f2=1 and f1=0.
//    Double producer: ADD r3; ADD r3; OR using r3 -> f1=1, f2=0.
//  3 Load-use: LW r2 then ADD r6,r2,r7 -> stall=1 for exactly 1 cycle, stall_cnt 0->1.
//    ADD then enters EX with fa_f2=1.
//  4 r0 / no-write: writes to r0 or regwrite=0 producers -> all selects 0, stall=0.
//    id_uses_rt=0 with rt match -> fb_*=0.
//  5 Flush: branch flush while LW r2 in EX and user in ID -> stall=0.
//    Next EX tag is a bubble and selects are 0.
//  6 Reset mid-stall, then stall_cnt preset near all-ones -> reset clears outputs in the
//    same cycle. Counter holds at all-ones under continuous stall.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - ALU operand forwarding select and load-use stall controller
// Tracks EX/MEM destination tags and registers F1/F2 selects one cycle ahead of EX.
module fwd_hazard_ctrl #(
  parameter int RA_W     = 4,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_uses_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             fa_f1,
  output logic             fa_f2,
  output logic             fb_f1,
  output logic             fb_f2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [RA_W-1:0]  r_ex_rd;
  logic             r_ex_rw;
  logic             r_ex_mr;
  logic [RA_W-1:0]  r_mem_rd;
  logic             r_mem_rw;
  logic             r_fa_f1;
  logic             r_fa_f2;
  logic             r_fb_f1;
  logic             r_fb_f2;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_ex_hit_rs;
  logic w_ex_hit_rt;
  logic w_mem_hit_rs;
  logic w_mem_hit_rt;
  logic w_stall;
  logic w_kill;
  logic w_fa_f1_n;
  logic w_fa_f2_n;
  logic w_fb_f1_n;
  logic w_fb_f2_n;

  // r0 is never a forwarding or stall source when it is hard-wired to zero.
  function automatic logic hit(input logic rw, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] r);
    return rw && (rd == r) && !(ZERO_REG && (r == '0));
  endfunction

  always_comb begin
    w_ex_hit_rs  = hit(r_ex_rw, r_ex_rd, id_rs);
    w_ex_hit_rt  = hit(r_ex_rw, r_ex_rd, id_rt) && id_uses_rt;
    w_mem_hit_rs = hit(r_mem_rw, r_mem_rd, id_rs);
    w_mem_hit_rt = hit(r_mem_rw, r_mem_rd, id_rt) && id_uses_rt;

    w_stall = !flush && r_ex_mr && (w_ex_hit_rs || w_ex_hit_rt);
    w_kill  = w_stall || flush;

    // A load in EX is never an F1 source; the stall covers it and F2 picks it up later.
    w_fa_f1_n = w_ex_hit_rs && !r_ex_mr;
    w_fa_f2_n = w_mem_hit_rs && !w_fa_f1_n;
    w_fb_f1_n = w_ex_hit_rt && !r_ex_mr;
    w_fb_f2_n = w_mem_hit_rt && !w_fb_f1_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_rd  <= '0;
      r_ex_rw  <= 1'b0;
      r_ex_mr  <= 1'b0;
      r_mem_rd <= '0;
      r_mem_rw <= 1'b0;
    end else begin
      r_mem_rd <= r_ex_rd;
      r_mem_rw <= r_ex_rw;
      if (w_kill) begin
        r_ex_rd <= '0;
        r_ex_rw <= 1'b0;
        r_ex_mr <= 1'b0;
      end else begin
        r_ex_rd <= id_rd;
        r_ex_rw <= id_regwrite;
        r_ex_mr <= id_memread;
      end
    end
  end

  // A bubble entering EX must take its operands straight from ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fa_f1 <= 1'b0;
      r_fa_f2 <= 1'b0;
      r_fb_f1 <= 1'b0;
      r_fb_f2 <= 1'b0;
    end else begin
      r_fa_f1 <= w_fa_f1_n && !w_kill;
      r_fa_f2 <= w_fa_f2_n && !w_kill;
      r_fb_f1 <= w_fb_f1_n && !w_kill;
      r_fb_f2 <= w_fb_f2_n && !w_kill;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fa_f1     = r_fa_f1;
  assign fa_f2     = r_fa_f2;
  assign fb_f1     = r_fb_f1;
  assign fb_f2     = r_fb_f2;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
